// File: rtl/jk_sync_down_counter.sv
// Synchronous down counter built from JK toggle cells on the falling clock edge.
// Adds parallel load, count enable, wrap/reload/one-shot terminal modes and a borrow pulse.
module jk_sync_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] toggle;

    // Bit i toggles when every lower bit is 0; at q==0 all bits toggle, giving the wrap.
    always_comb begin
        borrow    = '0;
        borrow[0] = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            borrow[i+1] = borrow[i] & ~q_q[i];
        end
        toggle = borrow[WIDTH-1:0] & {WIDTH{en}};
    end

    always_comb begin
        q_d     = q_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        state_d = state_q;
        if (ld) begin
            q_d     = din;
            rld_d   = din;
            done_d  = 1'b0;
            state_d = RUN;
        end else if (en && state_q != STOP) begin
            if (q_q != '0) begin
                q_d = q_q ^ toggle;
            end else begin
                tc_d = 1'b1;
                case (mode)
                    2'b01: q_d = rld_q;
                    2'b10: begin
                        q_d = '0;
                        if (state_q == RUN) begin
                            done_d  = 1'b1;
                            state_d = STOP;
                        end
                    end
                    default: q_d = q_q ^ toggle;
                endcase
            end
        end
    end

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            q_q     <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign zero = (q_q == '0);
    assign tc   = tc_q;
    assign done = done_q;

endmodule
